// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry, types and helpers for the direct-mapped instruction cache
// Holds the cache geometry (block/line/address widths and derived tag/index/offset widths),
// the FSM state encoding and block_t, which the memory controller also uses.
// Ports: none (package).
package icache_pkg;

    localparam int BLOCK_WIDTH = 1;
    localparam int CACHE_WIDTH = 8;
    localparam int ADDR_WIDTH  = 32;

    localparam int OFF_WIDTH  = BLOCK_WIDTH;
    localparam int IDX_WIDTH  = CACHE_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2;
    localparam int WORDS      = 1 << BLOCK_WIDTH;
    localparam int BLOCK_BITS = 32 << BLOCK_WIDTH;
    localparam int LINES      = 1 << CACHE_WIDTH;

    typedef logic [BLOCK_BITS-1:0] block_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;
    typedef logic [OFF_WIDTH-1:0]  off_t;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } ic_state_t;

    // Clears the word-offset and byte bits, giving the block-aligned address.
    localparam addr_t BLOCK_MASK = ~addr_t'((1 << (OFF_WIDTH + 2)) - 1);

    // Selects instruction word 'off' from a block; word 0 sits in [31:0].
    function automatic logic [31:0] block_word(input block_t b, input off_t off);
        logic [31:0] w;
        w = b[31:0];
        for (int i = 0; i < WORDS; i++) begin
            if (off == off_t'(i)) begin
                w = b[i*32 +: 32];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - data, tag and valid storage for the direct-mapped instruction cache
// One combinational read port (rd_idx -> rd_valid, rd_tag, rd_block) and one synchronous
// write port (we, wr_idx, wr_tag, wr_block). Only the valid bits are reset (asynchronously).
// Ports: clk, rst_n, rd_idx, rd_valid, rd_tag, rd_block, we, wr_idx, wr_tag, wr_block.
module icache_array
    import icache_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  idx_t   rd_idx,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output block_t rd_block,
    input  logic   we,
    input  idx_t   wr_idx,
    input  tag_t   wr_tag,
    input  block_t wr_block
);

    logic [LINES-1:0] valid;
    tag_t             tags [LINES];
    block_t           data [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_block;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_block = data[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache between instruction fetch and memory controller
// Hits reply one cycle after the request; misses issue one block read (ICMC_en held until
// MCIC_en), fill the line and reply. RoBIC_clear drops the pending reply but never the fill.
// Sys_rdy=0 freezes all state. Optional macro ICACHE_STAT_EN adds saturating hit/miss counters.
// Ports: Sys_clk, Sys_rst_n, Sys_rdy, IFIC_en/IFIC_addr (request), ICIF_en/ICIF_inst (reply),
//        RoBIC_clear (flush), ICMC_en/ICMC_addr (block read), MCIC_en/MCIC_block (fill),
//        ICstat_hit/ICstat_miss (ICACHE_STAT_EN only).
module icache_direct
    import icache_pkg::*;
(
    input  logic        Sys_clk,
    input  logic        Sys_rst_n,
    input  logic        Sys_rdy,
    input  logic        IFIC_en,
    input  addr_t       IFIC_addr,
    output logic        ICIF_en,
    output logic [31:0] ICIF_inst,
    input  logic        RoBIC_clear,
    output logic        ICMC_en,
    output addr_t       ICMC_addr,
    input  logic        MCIC_en,
    input  block_t      MCIC_block
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] ICstat_hit,
    output logic [31:0] ICstat_miss
`endif
);

    ic_state_t   state_q, state_d;
    tag_t        req_tag_q, req_tag_d;
    idx_t        req_idx_q, req_idx_d;
    off_t        req_off_q, req_off_d;
    logic        aborted_q, aborted_d;
    logic        icif_en_d;
    logic [31:0] icif_inst_d;
    logic        icmc_en_d;
    addr_t       icmc_addr_d;
    logic        fill;

    tag_t   in_tag;
    idx_t   in_idx;
    off_t   in_off;
    logic   rd_valid;
    tag_t   rd_tag;
    block_t rd_block;
    logic   accept;
    logic   hit;

    assign in_tag = IFIC_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign in_idx = IFIC_addr[OFF_WIDTH+2 +: IDX_WIDTH];
    assign in_off = IFIC_addr[2 +: OFF_WIDTH];

    icache_array u_array (
        .clk      (Sys_clk),
        .rst_n    (Sys_rst_n),
        .rd_idx   (in_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_block (rd_block),
        .we       (fill && Sys_rdy),
        .wr_idx   (req_idx_q),
        .wr_tag   (req_tag_q),
        .wr_block (MCIC_block)
    );

    // A clear in the request cycle wins; a reply still on the bus blocks acceptance.
    assign accept = (state_q == IC_IDLE) && IFIC_en && !RoBIC_clear && !ICIF_en;
    assign hit    = rd_valid && (rd_tag == in_tag);

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_off_d   = req_off_q;
        aborted_d   = aborted_q;
        icif_en_d   = 1'b0;
        icif_inst_d = ICIF_inst;
        icmc_en_d   = ICMC_en;
        icmc_addr_d = ICMC_addr;
        fill        = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = block_word(rd_block, in_off);
                    end else begin
                        icmc_en_d   = 1'b1;
                        icmc_addr_d = IFIC_addr & BLOCK_MASK;
                        req_tag_d   = in_tag;
                        req_idx_d   = in_idx;
                        req_off_d   = in_off;
                        aborted_d   = 1'b0;
                        state_d     = IC_MISS;
                    end
                end
            end
            IC_MISS: begin
                if (RoBIC_clear) begin
                    aborted_d = 1'b1;
                end
                // The fill happens even when aborted, so the MC transfer is never wasted.
                if (MCIC_en) begin
                    icmc_en_d = 1'b0;
                    fill      = 1'b1;
                    state_d   = IC_IDLE;
                    if (!aborted_q && !RoBIC_clear) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = block_word(MCIC_block, req_off_q);
                    end
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state_q   <= IC_IDLE;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            aborted_q <= 1'b0;
            ICIF_en   <= 1'b0;
            ICIF_inst <= '0;
            ICMC_en   <= 1'b0;
            ICMC_addr <= '0;
        end else if (Sys_rdy) begin
            state_q   <= state_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            aborted_q <= aborted_d;
            ICIF_en   <= icif_en_d;
            ICIF_inst <= icif_inst_d;
            ICMC_en   <= icmc_en_d;
            ICMC_addr <= icmc_addr_d;
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            ICstat_hit  <= '0;
            ICstat_miss <= '0;
        end else if (Sys_rdy && accept) begin
            if (hit && ICstat_hit != 32'hFFFF_FFFF) begin
                ICstat_hit <= ICstat_hit + 32'd1;
            end
            if (!hit && ICstat_miss != 32'hFFFF_FFFF) begin
                ICstat_miss <= ICstat_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct against a behavioural cache model
module tb_icache_direct;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst_n;
    logic        Sys_rdy;
    logic        IFIC_en;
    logic [31:0] IFIC_addr;
    logic        ICIF_en;
    logic [31:0] ICIF_inst;
    logic        RoBIC_clear;
    logic        ICMC_en;
    logic [31:0] ICMC_addr;
    logic        MCIC_en;
    logic [63:0] MCIC_block;
`ifdef ICACHE_STAT_EN
    logic [31:0] ICstat_hit;
    logic [31:0] ICstat_miss;
`endif

    icache_direct dut (
        .Sys_clk     (Sys_clk),
        .Sys_rst_n   (Sys_rst_n),
        .Sys_rdy     (Sys_rdy),
        .IFIC_en     (IFIC_en),
        .IFIC_addr   (IFIC_addr),
        .ICIF_en     (ICIF_en),
        .ICIF_inst   (ICIF_inst),
        .RoBIC_clear (RoBIC_clear),
        .ICMC_en     (ICMC_en),
        .ICMC_addr   (ICMC_addr),
        .MCIC_en     (MCIC_en),
        .MCIC_block  (MCIC_block)
`ifdef ICACHE_STAT_EN
        ,
        .ICstat_hit  (ICstat_hit),
        .ICstat_miss (ICstat_miss)
`endif
    );

    always #5 Sys_clk = ~Sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 256 lines of {valid, tag, two words}, indexed by plain arithmetic.
    bit          mvalid [256];
    logic [31:0] mtag   [256];
    logic [31:0] mdata  [256][2];
    int unsigned n_hit  = 0;
    int unsigned n_miss = 0;

    bit          force_blk = 1'b0;
    logic [63:0] forced_blk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        n_hit  = 0;
        n_miss = 0;
    endtask

    // clr_mode: 0 none, 1 clear with request, 2 clear while waiting on MC, 3 clear with MC return.
    task automatic fetch(input logic [31:0] addr, input int clr_mode, input bit stall);
        int          idx;
        int          off;
        logic [31:0] tg;
        logic [63:0] blk;
        bit          is_hit;
        int          lat;
        logic [31:0] want;
        idx    = int'((addr / 8) % 256);
        off    = int'((addr / 4) % 2);
        tg     = addr / 2048;
        is_hit = mvalid[idx] && (mtag[idx] == tg);

        @(negedge Sys_clk);
        IFIC_en     = 1'b1;
        IFIC_addr   = addr;
        RoBIC_clear = (clr_mode == 1);
        @(negedge Sys_clk);
        IFIC_en     = 1'b0;
        RoBIC_clear = 1'b0;
        IFIC_addr   = $urandom;

        if (clr_mode == 1) begin
            check("clr_req_no_reply", ICIF_en, 0);
            check("clr_req_no_mc", ICMC_en, 0);
            @(negedge Sys_clk);
            check("clr_req_idle_reply", ICIF_en, 0);
            check("clr_req_idle_mc", ICMC_en, 0);
            return;
        end

        if (is_hit) begin
            n_hit++;
            want = mdata[idx][off];
            check("hit_en", ICIF_en, 1);
            check("hit_inst", ICIF_inst, want);
            check("hit_no_mc", ICMC_en, 0);
            if (stall) begin
                Sys_rdy = 1'b0;
                repeat (2) begin
                    @(negedge Sys_clk);
                    check("stall_hit_en", ICIF_en, 1);
                    check("stall_hit_inst", ICIF_inst, want);
                end
                Sys_rdy = 1'b1;
            end
            @(negedge Sys_clk);
            check("hit_pulse_end", ICIF_en, 0);
            return;
        end

        n_miss++;
        check("miss_req", ICMC_en, 1);
        check("miss_addr", ICMC_addr, addr - (addr % 8));
        check("miss_no_reply", ICIF_en, 0);
        if (stall) begin
            Sys_rdy = 1'b0;
            repeat (3) begin
                @(negedge Sys_clk);
                check("stall_miss_mc", ICMC_en, 1);
                check("stall_miss_reply", ICIF_en, 0);
            end
            Sys_rdy = 1'b1;
        end
        lat = $urandom_range(3, 6);
        for (int i = 1; i < lat; i++) begin
            RoBIC_clear = (clr_mode == 2 && i == 2);
            @(negedge Sys_clk);
            RoBIC_clear = 1'b0;
            check("miss_hold_mc", ICMC_en, 1);
            check("miss_hold_reply", ICIF_en, 0);
        end
        blk         = force_blk ? forced_blk : {$urandom, $urandom};
        MCIC_en     = 1'b1;
        MCIC_block  = blk;
        RoBIC_clear = (clr_mode == 3);
        @(negedge Sys_clk);
        MCIC_en     = 1'b0;
        RoBIC_clear = 1'b0;
        MCIC_block  = {$urandom, $urandom};
        mvalid[idx]   = 1'b1;
        mtag[idx]     = tg;
        mdata[idx][0] = blk[31:0];
        mdata[idx][1] = blk[63:32];
        check("fill_mc_drop", ICMC_en, 0);
        if (clr_mode == 0) begin
            check("fill_reply", ICIF_en, 1);
            check("fill_inst", ICIF_inst, (off == 1) ? blk[63:32] : blk[31:0]);
        end else begin
            check("fill_aborted", ICIF_en, 0);
        end
        @(negedge Sys_clk);
        check("fill_pulse_end", ICIF_en, 0);
    endtask

    task automatic check_stats();
`ifdef ICACHE_STAT_EN
        check("stat_hit", ICstat_hit, n_hit);
        check("stat_miss", ICstat_miss, n_miss);
`endif
    endtask

    logic [31:0] pool_tag [4];
    logic [31:0] pool_idx [3];

    initial begin
        Sys_rst_n   = 1'b0;
        Sys_rdy     = 1'b1;
        IFIC_en     = 1'b0;
        IFIC_addr   = '0;
        RoBIC_clear = 1'b0;
        MCIC_en     = 1'b0;
        MCIC_block  = '0;
        model_reset();
        #12;
        check("rst_icif_en", ICIF_en, 0);
        check("rst_icif_inst", ICIF_inst, 0);
        check("rst_icmc_en", ICMC_en, 0);
        check("rst_icmc_addr", ICMC_addr, 0);
        check_stats();
        @(negedge Sys_clk);
        Sys_rst_n = 1'b1;

        // Cold miss then hit on the other word of the same block.
        force_blk  = 1'b1;
        forced_blk = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        fetch(32'h0000_0004, 0, 0);
        force_blk  = 1'b0;
        fetch(32'h0000_0000, 0, 0);
        check_stats();

        // Conflict on index 0: tag 1 evicts tag 0.
        fetch(32'h0000_0800, 0, 0);
        fetch(32'h0000_0000, 0, 0);

        // Clear while waiting on MC: line still fills.
        fetch(32'h0000_0010, 2, 0);
        fetch(32'h0000_0010, 0, 0);

        // Clear together with request: nothing happens, later fetch misses.
        fetch(32'h0000_0020, 1, 0);
        fetch(32'h0000_0020, 0, 0);

        // Clear in the MC return cycle: fill without reply.
        fetch(32'h0000_0048, 3, 0);
        fetch(32'h0000_004C, 0, 0);

        // Stalls on a hit reply and during a miss.
        fetch(32'h0000_0014, 0, 1);
        fetch(32'h1000_0040, 0, 1);

        // Last index.
        fetch(32'h0000_07F8, 0, 0);
        fetch(32'h0000_07FC, 0, 0);

        // Random traffic over a small address pool to mix hits, conflicts and clears.
        pool_tag[0] = 32'h0;
        pool_tag[1] = 32'h1;
        pool_tag[2] = 32'h2;
        pool_tag[3] = 32'h1F_FFFF;
        pool_idx[0] = 32'd0;
        pool_idx[1] = 32'd1;
        pool_idx[2] = 32'd255;
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int          r;
            a = pool_tag[$urandom_range(0, 3)] * 2048 + pool_idx[$urandom_range(0, 2)] * 8
                + $urandom_range(0, 1) * 4;
            r = $urandom_range(0, 9);
            fetch(a, (r < 7) ? 0 : r - 6, ($urandom_range(0, 7) == 0));
        end
        check_stats();

        // Asynchronous reset in the middle of a miss.
        @(negedge Sys_clk);
        IFIC_en   = 1'b1;
        IFIC_addr = 32'h7654_3210;
        @(negedge Sys_clk);
        IFIC_en = 1'b0;
        check("rstmiss_req", ICMC_en, 1);
        #2;
        Sys_rst_n = 1'b0;
        #1;
        check("rstmiss_mc_drop", ICMC_en, 0);
        check("rstmiss_mc_addr", ICMC_addr, 0);
        check("rstmiss_reply", ICIF_en, 0);
        model_reset();
        check_stats();
        @(negedge Sys_clk);
        Sys_rst_n = 1'b1;
        fetch(32'h0000_0010, 0, 0);
        fetch(32'h0000_0010, 0, 0);
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
